// File: rtl/led_sweep_top_if.sv
// Switch/button inputs and LED outputs of the LED sweep generator.
interface led_sweep_top_if #(
  parameter int NB_SW   = 4,
  parameter int NB_BTN  = 4,
  parameter int NB_LEDS = 4
);
  logic [NB_SW-1:0]   i_sw;
  logic [NB_BTN-1:0]  i_btn;
  logic [NB_LEDS-1:0] o_led;
  logic [NB_LEDS-1:0] o_led_r;
  logic [NB_LEDS-1:0] o_led_g;
  logic [NB_LEDS-1:0] o_led_b;

  modport master (output i_sw, i_btn, input o_led, o_led_r, o_led_g, o_led_b);
  modport slave  (input i_sw, i_btn, output o_led, o_led_r, o_led_g, o_led_b);
endinterface

// File: rtl/led_sweep_top.sv
// LED pattern generator: prescaled flash / single sweep / pair sweep on a selectable RGB channel.
// Define LED_SWEEP_BTN_SYNC_EN to add a 2-flop synchronizer on every button bit.
module led_sweep_top #(
  parameter int NB_SW      = 4,
  parameter int NB_BTN     = 4,
  parameter int NB_COUNTER = 32,
  parameter int NB_LEDS    = 4
) (
  input logic            clock,
  input logic            i_reset,
  led_sweep_top_if.slave bus
);
  typedef enum logic [1:0] {FLASH, SHIFT, PAIR} mode_t;
  typedef enum logic [1:0] {RED, GREEN, BLUE} color_t;

  localparam logic [NB_LEDS-1:0] PAIR_ENDS = {1'b1, {(NB_LEDS-2){1'b0}}, 1'b1};
  localparam logic [NB_LEDS-1:0] LED_ONE   = {{(NB_LEDS-1){1'b0}}, 1'b1};
  localparam logic [NB_LEDS-1:0] LED_MSB   = {1'b1, {(NB_LEDS-1){1'b0}}};

  logic [NB_SW-1:0]      sw;
  logic [NB_BTN-1:0]     btn_s;
  logic [NB_BTN-1:0]     btn_hist_reg;
  logic [NB_BTN-1:0]     btn_edge_reg;
  logic [NB_COUNTER-1:0] counter_reg, counter_next, limit;
  logic [NB_LEDS-1:0]    pattern_reg, pattern_next;
  logic [NB_LEDS-1:0]    led_reg, led_r_reg, led_g_reg, led_b_reg;
  mode_t                 mode_reg, mode_next;
  color_t                color_reg, color_next;

  assign sw = bus.i_sw;

`ifdef LED_SWEEP_BTN_SYNC_EN
  logic [NB_BTN-1:0] sync1_reg, sync2_reg;

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= bus.i_btn;
      sync2_reg <= sync1_reg;
    end
  end

  assign btn_s = sync2_reg;
`else
  assign btn_s = bus.i_btn;
`endif

  always_comb begin
    limit        = {NB_COUNTER{1'b1}} >> sw[2:1];
    mode_next    = mode_reg;
    color_next   = color_reg;
    pattern_next = pattern_reg;
    counter_next = counter_reg;

    if (btn_edge_reg[1])      color_next = RED;
    else if (btn_edge_reg[2]) color_next = GREEN;
    else if (btn_edge_reg[3]) color_next = BLUE;

    // A mode change restarts the step period, so any tick this cycle is dropped.
    if (btn_edge_reg[0]) begin
      counter_next = '0;
      case (mode_reg)
        FLASH: begin
          mode_next    = SHIFT;
          pattern_next = sw[3] ? LED_ONE : LED_MSB;
        end
        SHIFT: begin
          mode_next    = PAIR;
          pattern_next = sw[3] ? ~PAIR_ENDS : PAIR_ENDS;
        end
        default: begin
          mode_next    = FLASH;
          pattern_next = '0;
        end
      endcase
    end else if (!sw[0]) begin
      counter_next = '0;
    end else if (counter_reg >= limit) begin
      counter_next = '0;
      if (mode_reg == SHIFT)
        pattern_next = sw[3] ? {pattern_reg[NB_LEDS-2:0], pattern_reg[NB_LEDS-1]}
                             : {pattern_reg[0], pattern_reg[NB_LEDS-1:1]};
      else
        pattern_next = ~pattern_reg;
    end else begin
      counter_next = counter_reg + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      btn_hist_reg <= '0;
      btn_edge_reg <= '0;
      counter_reg  <= '0;
      pattern_reg  <= '0;
      mode_reg     <= FLASH;
      color_reg    <= RED;
      led_reg      <= LED_ONE;
      led_r_reg    <= '0;
      led_g_reg    <= '0;
      led_b_reg    <= '0;
    end else begin
      btn_hist_reg <= btn_s;
      btn_edge_reg <= btn_s & ~btn_hist_reg;
      counter_reg  <= counter_next;
      pattern_reg  <= pattern_next;
      mode_reg     <= mode_next;
      color_reg    <= color_next;
      // Outputs are loaded from the next-state values so they track state without extra delay.
      case (mode_next)
        SHIFT:   led_reg <= NB_LEDS'(2);
        PAIR:    led_reg <= NB_LEDS'(4);
        default: led_reg <= LED_ONE;
      endcase
      led_r_reg <= (color_next == RED)   ? pattern_next : '0;
      led_g_reg <= (color_next == GREEN) ? pattern_next : '0;
      led_b_reg <= (color_next == BLUE)  ? pattern_next : '0;
    end
  end

  assign bus.o_led   = led_reg;
  assign bus.o_led_r = led_r_reg;
  assign bus.o_led_g = led_g_reg;
  assign bus.o_led_b = led_b_reg;
endmodule

// File: tb/tb_led_sweep_top.sv
// Bench for led_sweep_top: directed mode/colour steps plus random button traffic, checked every cycle.
module tb_led_sweep_top;
  localparam int NBC = 16;

  logic clock;
  logic i_reset;
  int   total = 0;
  int   bad   = 0;

  led_sweep_top_if #(.NB_SW(4), .NB_BTN(4), .NB_LEDS(4)) bus ();

  led_sweep_top #(.NB_SW(4), .NB_BTN(4), .NB_COUNTER(NBC), .NB_LEDS(4)) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: mode 0/1/2 = flash/shift/pair, colour 0/1/2 = red/green/blue.
  int m_mode, m_pat, m_color, m_cnt, m_prev, m_edge, m_d1, m_d2;

  task automatic model_clock();
    int sw, bs, lim, dir;
    if (!i_reset) begin
      m_mode = 0; m_pat = 0; m_color = 0; m_cnt = 0;
      m_prev = 0; m_edge = 0; m_d1 = 0; m_d2 = 0;
      return;
    end
    sw  = int'(bus.i_sw);
    dir = (sw >> 3) & 1;
`ifdef LED_SWEEP_BTN_SYNC_EN
    bs = m_d2; m_d2 = m_d1; m_d1 = int'(bus.i_btn);
`else
    bs = int'(bus.i_btn);
`endif
    lim = (1 << (NBC - ((sw >> 1) & 3))) - 1;
    if ((m_edge & 2) != 0)      m_color = 0;
    else if ((m_edge & 4) != 0) m_color = 1;
    else if ((m_edge & 8) != 0) m_color = 2;
    if ((m_edge & 1) != 0) begin
      m_mode = (m_mode + 1) % 3;
      m_cnt  = 0;
      m_pat  = (m_mode == 0) ? 0 : (m_mode == 1) ? (dir ? 1 : 8) : (dir ? 6 : 9);
    end else if ((sw & 1) == 0) begin
      m_cnt = 0;
    end else if (m_cnt >= lim) begin
      m_cnt = 0;
      if (m_mode == 1)
        m_pat = dir ? (((m_pat * 2) % 16) + m_pat / 8) : ((m_pat / 2) + (m_pat % 2) * 8);
      else
        m_pat = 15 - m_pat;
    end else begin
      m_cnt++;
    end
    m_edge = bs & ~m_prev & 15;
    m_prev = bs;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_clock();
    #1;
    chk("cyc_led",   bus.o_led,   4'(1 << m_mode));
    chk("cyc_led_r", bus.o_led_r, (m_color == 0) ? 4'(m_pat) : 4'b0000);
    chk("cyc_led_g", bus.o_led_g, (m_color == 1) ? 4'(m_pat) : 4'b0000);
    chk("cyc_led_b", bus.o_led_b, (m_color == 2) ? 4'(m_pat) : 4'b0000);
  endtask

  task automatic press(input logic [3:0] bits);
    bus.i_btn = bits;
    step();
    bus.i_btn = 4'b0000;
    repeat (3 + $urandom_range(0, 3)) step();
  endtask

  task automatic wait_toggle(input string tag, output int n);
    logic [3:0] prev;
    prev = bus.o_led_r;
    n = 0;
    while (bus.o_led_r === prev && n < 70000) begin
      step();
      n++;
    end
    total++;
    assert (n < 70000) else begin
      bad++;
      $error("FAIL %s: observed=timeout expected=pattern change", tag);
    end
  endtask

  initial begin
    int n;
    i_reset   = 1'b0;
    bus.i_sw  = 4'($urandom);
    bus.i_btn = 4'($urandom);

    repeat (5) begin
      bus.i_sw  = 4'($urandom);
      bus.i_btn = 4'($urandom);
      step();
      chk("rst_led",   bus.o_led,   4'b0001);
      chk("rst_led_r", bus.o_led_r, 4'b0000);
      chk("rst_led_g", bus.o_led_g, 4'b0000);
      chk("rst_led_b", bus.o_led_b, 4'b0000);
    end

    bus.i_sw  = 4'b0000;
    bus.i_btn = 4'b0000;
    i_reset   = 1'b1;
    repeat (1000) step();
    chk("idle_led",   bus.o_led,   4'b0001);
    chk("idle_led_r", bus.o_led_r, 4'b0000);

    // Flash at the fastest speed: 8192-cycle step period.
    bus.i_sw = 4'b0111;
    wait_toggle("flash_t1", n);
    chk_int("flash_period1", n, 8192);
    chk("flash_on", bus.o_led_r, 4'b1111);
    wait_toggle("flash_t2", n);
    chk_int("flash_period2", n, 8192);
    chk("flash_off", bus.o_led_r, 4'b0000);

    // Shift, left-to-right, then reverse direction mid-sweep.
    press(4'b0001);
    chk("shift_led",   bus.o_led,   4'b0010);
    chk("shift_start", bus.o_led_r, 4'b1000);
    wait_toggle("shift_t1", n);
    chk("shift_1", bus.o_led_r, 4'b0100);
    wait_toggle("shift_t2", n);
    chk("shift_2", bus.o_led_r, 4'b0010);
    bus.i_sw = 4'b1111;
    wait_toggle("shift_t3", n);
    chk("shift_rev", bus.o_led_r, 4'b0100);

    // Pair, centre-out start.
    press(4'b0001);
    chk("pair_led",   bus.o_led,   4'b0100);
    chk("pair_start", bus.o_led_r, 4'b0110);
    wait_toggle("pair_t1", n);
    chk("pair_1", bus.o_led_r, 4'b1001);

    // Wrap to flash, come round again and enter pair with ends-in start.
    press(4'b0001);
    chk("wrap_led", bus.o_led,   4'b0001);
    chk("wrap_pat", bus.o_led_r, 4'b0000);
    press(4'b0001);
    chk("shift2_start", bus.o_led_r, 4'b0001);
    bus.i_sw = 4'b0111;
    press(4'b0001);
    chk("pair2_led",   bus.o_led,   4'b0100);
    chk("pair2_start", bus.o_led_r, 4'b1001);
    press(4'b0001);
    chk("wrap2_led", bus.o_led, 4'b0001);

    // Held mode button steps exactly once.
    bus.i_btn = 4'b0001;
    repeat (5000) step();
    chk("hold_led", bus.o_led, 4'b0010);
    bus.i_btn = 4'b0000;
    repeat (5) step();
    chk("hold_after_led", bus.o_led,   4'b0010);
    chk("hold_after_pat", bus.o_led_r, 4'b1000);

    // Colour selection, including red-over-blue priority.
    press(4'b0100);
    chk("green_g", bus.o_led_g, 4'b1000);
    chk("green_r", bus.o_led_r, 4'b0000);
    chk("green_b", bus.o_led_b, 4'b0000);
    press(4'b1010);
    chk("prio_r", bus.o_led_r, 4'b1000);
    chk("prio_g", bus.o_led_g, 4'b0000);
    chk("prio_b", bus.o_led_b, 4'b0000);
    press(4'b1000);
    chk("blue_b", bus.o_led_b, 4'b1000);
    chk("blue_r", bus.o_led_r, 4'b0000);

    // Random button and switch traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) bus.i_sw = 4'($urandom) | 4'b0110;
      bus.i_btn = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      step();
    end
    bus.i_btn = 4'b0000;
    repeat (8) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
